// File: rtl/balance_seq_if.sv
// Bundles the balance sequencer's rider/inertial inputs and PID/motor control outputs.
// The master modport drives the inputs and the slave modport is used by balance_seq.
interface balance_seq_if;
  logic        pwr_btn;
  logic        ptch_vld;
  logic [15:0] ptch;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [7:0]  ss_tmr;
  logic        sys_on;
  logic        pwr_up;
  logic        rider_off;
  logic        pid_vld;
  logic        mtr_en;
  logic        ss_active;
  logic        tilt_fault;
  logic [2:0]  state;

  modport master (
    output pwr_btn, ptch_vld, ptch, lft_ld, rght_ld, ss_tmr,
    input  sys_on, pwr_up, rider_off, pid_vld, mtr_en, ss_active, tilt_fault, state
  );

  modport slave (
    input  pwr_btn, ptch_vld, ptch, lft_ld, rght_ld, ss_tmr,
    output sys_on, pwr_up, rider_off, pid_vld, mtr_en, ss_active, tilt_fault, state
  );
endinterface

// File: rtl/balance_seq.sv
// Self-balancing platform power/rider/tilt sequencer.
// All outputs are registered and decoded from the next state, so they move with state.
module balance_seq #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter logic [15:0] TILT_LIM     = 16'h0800,
  parameter logic [2:0]  FAULT_CNT    = 3'd4
) (
  input  logic         clk,
  input  logic         rst,
  balance_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_WAIT_RIDER = 3'd1,
    ST_SOFT_START = 3'd2,
    ST_BALANCE    = 3'd3,
    ST_TILT_FAULT = 3'd4
  } state_t;

  localparam logic [12:0] RIDER_ON_WT  = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] RIDER_OFF_WT = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};
  localparam logic [16:0] TILT_MAG     = {1'b0, TILT_LIM};

  state_t      state_q, state_d;
  logic        rider_present_q, rider_present_d;
  logic [2:0]  tilt_cnt_q, tilt_cnt_d;
  logic        sys_on_q, sys_on_d;
  logic        pwr_up_q, pwr_up_d;
  logic        rider_off_q, rider_off_d;
  logic        pid_vld_q, pid_vld_d;
  logic        ss_active_q, ss_active_d;
  logic        tilt_fault_q, tilt_fault_d;

  logic [12:0] wt_sum_s;
  logic [16:0] ptch_mag_s;
  logic        over_tilt_s;
  logic        run_cur_s;
  logic        run_nxt_s;
  logic [2:0]  cnt_inc_s;
  logic        fault_trip_s;

  // Rider detection, tilt magnitude and fault-trip qualification.
  always_comb begin
    wt_sum_s        = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    rider_present_d = rider_present_q;
    if (wt_sum_s > RIDER_ON_WT) begin
      rider_present_d = 1'b1;
    end else if (wt_sum_s < RIDER_OFF_WT) begin
      rider_present_d = 1'b0;
    end else begin
      rider_present_d = rider_present_q;
    end

    // 17-bit magnitude so that 16'h8000 negates to 32768 instead of wrapping.
    ptch_mag_s   = bus.ptch[15] ? ({1'b0, ~bus.ptch} + 17'd1) : {1'b0, bus.ptch};
    over_tilt_s  = (ptch_mag_s > TILT_MAG);
    run_cur_s    = (state_q == ST_SOFT_START) || (state_q == ST_BALANCE);
    cnt_inc_s    = (tilt_cnt_q >= FAULT_CNT) ? FAULT_CNT : (tilt_cnt_q + 3'd1);
    fault_trip_s = run_cur_s && bus.ptch_vld && over_tilt_s && (cnt_inc_s >= FAULT_CNT);
  end

  // Next-state logic; priority is power button, tilt fault, rider loss, soft-start done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (bus.pwr_btn) state_d = ST_WAIT_RIDER;
        else             state_d = ST_OFF;
      end
      ST_WAIT_RIDER: begin
        if (bus.pwr_btn)          state_d = ST_OFF;
        else if (rider_present_q) state_d = ST_SOFT_START;
        else                      state_d = ST_WAIT_RIDER;
      end
      ST_SOFT_START: begin
        if (bus.pwr_btn)              state_d = ST_OFF;
        else if (fault_trip_s)        state_d = ST_TILT_FAULT;
        else if (!rider_present_q)    state_d = ST_WAIT_RIDER;
        else if (bus.ss_tmr == 8'hFF) state_d = ST_BALANCE;
        else                          state_d = ST_SOFT_START;
      end
      ST_BALANCE: begin
        if (bus.pwr_btn)           state_d = ST_OFF;
        else if (fault_trip_s)     state_d = ST_TILT_FAULT;
        else if (!rider_present_q) state_d = ST_WAIT_RIDER;
        else                       state_d = ST_BALANCE;
      end
      ST_TILT_FAULT: begin
        if (bus.pwr_btn) state_d = ST_OFF;
        else             state_d = ST_TILT_FAULT;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Tilt counter and output decode from the next state.
  always_comb begin
    run_nxt_s  = (state_d == ST_SOFT_START) || (state_d == ST_BALANCE);
    tilt_cnt_d = tilt_cnt_q;
    if (!(run_cur_s && run_nxt_s)) begin
      tilt_cnt_d = 3'd0;
    end else if (bus.ptch_vld) begin
      tilt_cnt_d = over_tilt_s ? cnt_inc_s : 3'd0;
    end else begin
      tilt_cnt_d = tilt_cnt_q;
    end

    sys_on_d     = (state_d != ST_OFF);
    pwr_up_d     = run_nxt_s;
    rider_off_d  = !run_nxt_s;
    ss_active_d  = (state_d == ST_SOFT_START);
    tilt_fault_d = (state_d == ST_TILT_FAULT);
    pid_vld_d    = bus.ptch_vld && run_nxt_s;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_OFF;
      rider_present_q <= 1'b0;
      tilt_cnt_q      <= 3'd0;
      sys_on_q        <= 1'b0;
      pwr_up_q        <= 1'b0;
      rider_off_q     <= 1'b1;
      pid_vld_q       <= 1'b0;
      ss_active_q     <= 1'b0;
      tilt_fault_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      rider_present_q <= rider_present_d;
      tilt_cnt_q      <= tilt_cnt_d;
      sys_on_q        <= sys_on_d;
      pwr_up_q        <= pwr_up_d;
      rider_off_q     <= rider_off_d;
      pid_vld_q       <= pid_vld_d;
      ss_active_q     <= ss_active_d;
      tilt_fault_q    <= tilt_fault_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.sys_on     = sys_on_q;
  assign bus.pwr_up     = pwr_up_q;
  assign bus.mtr_en     = pwr_up_q;
  assign bus.rider_off  = rider_off_q;
  assign bus.pid_vld    = pid_vld_q;
  assign bus.ss_active  = ss_active_q;
  assign bus.tilt_fault = tilt_fault_q;

endmodule

// File: tb/tb_balance_seq.sv
// Directed and randomized bench for balance_seq, checked against a behavioural model.
module tb_balance_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  balance_seq_if bus ();

  balance_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam int MIN_WT = 512;
  localparam int LOW_WT = 448;
  localparam int TLIM   = 2048;
  localparam int FCNT   = 4;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=OFF 1=WAIT_RIDER 2=SOFT_START 3=BALANCE 4=TILT_FAULT
  int m_state;
  bit m_rider;
  int m_cnt;
  bit m_pid;

  logic [15:0] ptch_tbl [8];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_rider = 1'b0;
    m_cnt   = 0;
    m_pid   = 1'b0;
  endtask

  function automatic bit active(input int s);
    return (s == 2) || (s == 3);
  endfunction

  task automatic model_step();
    int  wt;
    int  p;
    int  mag;
    bit  over;
    bit  trip;
    int  nxt;
    int  cnt;
    wt   = int'(bus.lft_ld) + int'(bus.rght_ld);
    p    = int'($signed(bus.ptch));
    mag  = (p < 0) ? -p : p;
    over = (mag > TLIM);
    trip = 1'b0;
    cnt  = m_cnt;
    if (active(m_state) && bus.ptch_vld) begin
      if (over) begin
        cnt  = (m_cnt + 1 > FCNT) ? FCNT : m_cnt + 1;
        trip = (cnt == FCNT);
      end else begin
        cnt = 0;
      end
    end
    nxt = m_state;
    if (m_state == 0) begin
      if (bus.pwr_btn) nxt = 1;
    end else if (bus.pwr_btn) begin
      nxt = 0;
    end else if (m_state == 1) begin
      if (m_rider) nxt = 2;
    end else if (active(m_state)) begin
      if (trip) nxt = 4;
      else if (!m_rider) nxt = 1;
      else if (m_state == 2 && bus.ss_tmr == 8'hFF) nxt = 3;
    end
    if (!(active(m_state) && active(nxt))) cnt = 0;
    m_pid = bus.ptch_vld && active(nxt);
    if (wt > MIN_WT) m_rider = 1'b1;
    else if (wt < LOW_WT) m_rider = 1'b0;
    m_cnt   = cnt;
    m_state = nxt;
  endtask

  task automatic check_model(input string tag);
    chk3({tag, "_state"}, bus.state, 3'(m_state));
    chk1({tag, "_sys_on"}, bus.sys_on, m_state != 0);
    chk1({tag, "_pwr_up"}, bus.pwr_up, active(m_state));
    chk1({tag, "_mtr_en"}, bus.mtr_en, active(m_state));
    chk1({tag, "_rider_off"}, bus.rider_off, !active(m_state));
    chk1({tag, "_ss_active"}, bus.ss_active, m_state == 2);
    chk1({tag, "_tilt_fault"}, bus.tilt_fault, m_state == 4);
    chk1({tag, "_pid_vld"}, bus.pid_vld, m_pid);
  endtask

  task automatic cycle(input bit btn, input bit vld, input logic [15:0] p);
    bus.pwr_btn  = btn;
    bus.ptch_vld = vld;
    bus.ptch     = p;
    model_step();
    @(posedge clk);
    #1;
    check_model("model");
    bus.pwr_btn  = 1'b0;
    bus.ptch_vld = 1'b0;
  endtask

  task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
    bus.lft_ld  = l;
    bus.rght_ld = r;
  endtask

  task automatic check_reset_vals(input string tag);
    chk3({tag, "_state"}, bus.state, 3'd0);
    chk1({tag, "_sys_on"}, bus.sys_on, 1'b0);
    chk1({tag, "_pwr_up"}, bus.pwr_up, 1'b0);
    chk1({tag, "_mtr_en"}, bus.mtr_en, 1'b0);
    chk1({tag, "_rider_off"}, bus.rider_off, 1'b1);
    chk1({tag, "_ss_active"}, bus.ss_active, 1'b0);
    chk1({tag, "_tilt_fault"}, bus.tilt_fault, 1'b0);
    chk1({tag, "_pid_vld"}, bus.pid_vld, 1'b0);
  endtask

  // Power up with a rider on board and ride through soft-start into BALANCE.
  task automatic go_balance();
    set_ld(12'h150, 12'h150);
    bus.ss_tmr = 8'h00;
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    bus.ss_tmr = 8'hFF;
    cycle(1'b0, 1'b0, 16'h0000);
    bus.ss_tmr = 8'h00;
    chk3("go_balance_state", bus.state, 3'd3);
  endtask

  initial begin
    ptch_tbl[0] = 16'h0800; ptch_tbl[1] = 16'hF800;
    ptch_tbl[2] = 16'h0801; ptch_tbl[3] = 16'hF7FF;
    ptch_tbl[4] = 16'h8000; ptch_tbl[5] = 16'h0100;
    ptch_tbl[6] = 16'h0900; ptch_tbl[7] = 16'hF700;
    bus.pwr_btn  = 1'b0;
    bus.ptch_vld = 1'b0;
    bus.ptch     = 16'h0000;
    bus.ss_tmr   = 8'h00;
    set_ld(12'h000, 12'h000);
    model_reset();

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // No pwr_btn: stays OFF even with a rider present.
    set_ld(12'h150, 12'h150);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    chk3("off_needs_btn", bus.state, 3'd0);

    // Power up: one cycle WAIT_RIDER, then SOFT_START.
    cycle(1'b1, 1'b0, 16'h0000);
    chk3("pwr_wait", bus.state, 3'd1);
    cycle(1'b0, 1'b0, 16'h0000);
    chk3("ss_state", bus.state, 3'd2);
    chk1("ss_pwr_up", bus.pwr_up, 1'b1);
    chk1("ss_mtr_en", bus.mtr_en, 1'b1);
    chk1("ss_active", bus.ss_active, 1'b1);
    chk1("ss_rider_off", bus.rider_off, 1'b0);

    // Soft-start completion and pid_vld latency.
    bus.ss_tmr = 8'hFE;
    cycle(1'b0, 1'b0, 16'h0000);
    chk3("ss_fe_hold", bus.state, 3'd2);
    bus.ss_tmr = 8'hFF;
    cycle(1'b0, 1'b0, 16'h0000);
    chk3("bal_state", bus.state, 3'd3);
    chk1("bal_ss_active", bus.ss_active, 1'b0);
    bus.ss_tmr = 8'h00;
    cycle(1'b0, 1'b1, 16'h0010);
    chk1("pid_vld_hi", bus.pid_vld, 1'b1);
    cycle(1'b0, 1'b0, 16'h0010);
    chk1("pid_vld_lo", bus.pid_vld, 1'b0);

    // Weight hysteresis: 0x1D0 holds, 0x1BF drops the rider.
    set_ld(12'h0E8, 12'h0E8);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    chk3("wt_1d0_hold", bus.state, 3'd3);
    set_ld(12'h0DF, 12'h0E0);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    chk3("wt_1bf_wait", bus.state, 3'd1);
    chk1("wt_1bf_pwr_up", bus.pwr_up, 1'b0);
    chk1("wt_1bf_rider_off", bus.rider_off, 1'b1);

    // Remount and tilt fault after an interrupted over-tilt run.
    set_ld(12'h150, 12'h150);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    bus.ss_tmr = 8'hFF;
    cycle(1'b0, 1'b0, 16'h0000);
    bus.ss_tmr = 8'h00;
    chk3("remount_bal", bus.state, 3'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0900);
    cycle(1'b0, 1'b1, 16'h0100);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'hF700);
    chk3("tilt_3neg_bal", bus.state, 3'd3);
    cycle(1'b0, 1'b1, 16'hF700);
    chk3("tilt_fault_state", bus.state, 3'd4);
    chk1("tilt_fault_out", bus.tilt_fault, 1'b1);
    set_ld(12'h010, 12'h010);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    set_ld(12'h150, 12'h150);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    chk3("fault_ignores_rider", bus.state, 3'd4);
    cycle(1'b1, 1'b0, 16'h0000);
    chk3("fault_btn_off", bus.state, 3'd0);

    // pwr_btn coinciding with the tripping sample wins.
    go_balance();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h8000);
    cycle(1'b1, 1'b1, 16'h8000);
    chk3("btn_vs_trip_state", bus.state, 3'd0);
    chk1("btn_vs_trip_fault", bus.tilt_fault, 1'b0);

    // Asynchronous reset mid-BALANCE.
    go_balance();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] p;
      if ($urandom_range(0, 49) == 0)
        set_ld(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      else if ($urandom_range(0, 7) == 0)
        set_ld(12'($urandom_range(192, 320)), 12'($urandom_range(192, 320)));
      bus.ss_tmr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      if ($urandom_range(0, 3) == 0) p = 16'($urandom);
      else p = ptch_tbl[$urandom_range(0, 7)];
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
